// File: rtl/kernel_clk_meter_pkg.sv
// Shared types and default sizing for the kernel clock meter.
package kernel_clk_meter_pkg;

  localparam int CNT_W_DEF   = 24;
  localparam int TIMEOUT_DEF = 10_000_000;

  typedef enum logic [1:0] {
    ST_WAIT_FIRST = 2'd0,
    ST_MEASURE    = 2'd1,
    ST_STALLED    = 2'd2
  } meter_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous tap into the reference domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Plain two-stage shift; both stages clear under reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/kernel_clk_meter.sv
// Measures the period of a divided kernel-clock tap in reference-clock cycles,
// tracks min/max statistics, counts tap edges and flags a stalled kernel clock.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_WAIT_FIRST | no reference edge yet; next edge only arms measurement
// ST_MEASURE    | counting cycles since the last edge; next edge ends a period
// ST_STALLED    | no edge for TIMEOUT cycles; next edge re-arms, no period
module kernel_clk_meter
  import kernel_clk_meter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             fpga_clk_50,
  input  logic             fpga_reset_n,
  input  logic             tap_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max,
  output logic             stalled,
  output logic [15:0]      edge_count
);

  localparam logic [CNT_W-1:0] CNT_ALL1 = {CNT_W{1'b1}};
  // Compare in at least 32 bits so a TIMEOUT wider than the counter simply
  // never matches (the counter saturates first and no stall is raised).
  localparam int               EXT_W    = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [EXT_W-1:0] CNT_LAST = EXT_W'(TIMEOUT - 1);

  logic             tap_sync;
  logic             tap_q;
  logic             rise_det;
  meter_state_e     state;
  meter_state_e     state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_new;
  logic             at_timeout;
  logic             cnt_restart;
  logic             cnt_run;
  logic             meas_done;
  logic             stall_set;

  sync_2ff u_sync (
    .clk   (fpga_clk_50),
    .rst_n (fpga_reset_n),
    .d     (tap_in),
    .q     (tap_sync)
  );

  // Edge register: one cycle of history on the synchronized tap.
  always_ff @(posedge fpga_clk_50) begin
    if (!fpga_reset_n) tap_q <= 1'b0;
    else               tap_q <= tap_sync;
  end

  assign rise_det   = tap_sync & ~tap_q;
  assign at_timeout = (EXT_W'(cnt) == CNT_LAST);
  // cnt holds cycles-since-edge minus one, so the period is cnt+1 (saturated).
  assign period_new = (cnt == CNT_ALL1) ? CNT_ALL1 : cnt + 1'b1;

  // State register.
  always_ff @(posedge fpga_clk_50) begin
    if (!fpga_reset_n) state <= ST_WAIT_FIRST;
    else               state <= state_nxt;
  end

  // Next-state and datapath controls; clear overrides any coincident edge,
  // and an edge overrides a coincident timeout.
  always_comb begin
    state_nxt   = state;
    cnt_restart = 1'b0;
    cnt_run     = 1'b0;
    meas_done   = 1'b0;
    stall_set   = 1'b0;
    if (clear) begin
      state_nxt = ST_WAIT_FIRST;
    end else begin
      case (state)
        ST_WAIT_FIRST: begin
          if (rise_det) begin
            state_nxt   = ST_MEASURE;
            cnt_restart = 1'b1;
          end else if (at_timeout) begin
            state_nxt = ST_STALLED;
            stall_set = 1'b1;
          end else begin
            cnt_run = 1'b1;
          end
        end
        ST_MEASURE: begin
          if (rise_det) begin
            meas_done   = 1'b1;
            cnt_restart = 1'b1;
          end else if (at_timeout) begin
            state_nxt = ST_STALLED;
            stall_set = 1'b1;
          end else begin
            cnt_run = 1'b1;
          end
        end
        ST_STALLED: begin
          if (rise_det) begin
            state_nxt   = ST_MEASURE;
            cnt_restart = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_WAIT_FIRST;
        end
      endcase
    end
  end

  // Cycle counter: restarts on an accepted edge, saturates at all-ones,
  // freezes while stalled.
  always_ff @(posedge fpga_clk_50) begin
    if (!fpga_reset_n) begin
      cnt <= '0;
    end else if (clear || cnt_restart) begin
      cnt <= '0;
    end else if (cnt_run && (cnt != CNT_ALL1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Period result and its one-cycle valid strobe; period_out survives clear.
  always_ff @(posedge fpga_clk_50) begin
    if (!fpga_reset_n) begin
      period_out   <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= meas_done;
      if (meas_done) period_out <= period_new;
    end
  end

  // Min/max statistics, updated alongside period_out.
  always_ff @(posedge fpga_clk_50) begin
    if (!fpga_reset_n || clear) begin
      period_min <= CNT_ALL1;
      period_max <= '0;
    end else if (meas_done) begin
      if (period_new < period_min) period_min <= period_new;
      if (period_new > period_max) period_max <= period_new;
    end
  end

  // Stall flag: raised on timeout, dropped by the next accepted edge.
  always_ff @(posedge fpga_clk_50) begin
    if (!fpga_reset_n || clear) begin
      stalled <= 1'b0;
    end else if (stall_set) begin
      stalled <= 1'b1;
    end else if (cnt_restart) begin
      stalled <= 1'b0;
    end
  end

  // Edge counter: every detected edge in any state, unless clear is present.
  always_ff @(posedge fpga_clk_50) begin
    if (!fpga_reset_n || clear) begin
      edge_count <= '0;
    end else if (rise_det) begin
      edge_count <= sat_inc16(edge_count);
    end
  end

endmodule
